mag_cmp: RTL and testbench
==========================

MAG_CMP -- requirements
Module: mag_cmp

Interface
REQ-001 Parameter: WIDTH, default 2, operand width in bits, legal range 1..32.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock of the block.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  operands on a/b are to be compared this cycle.
REQ-005 Port: a  input  WIDTH  operand A.
REQ-006 Port: b  input  WIDTH  operand B.
REQ-007 Port: c  output  1  registered flag, A greater than B.
REQ-008 Port: d  output  1  registered flag, A equal to B.
REQ-009 Port: e  output  1  registered flag, A less than B.
REQ-010 Port: out_valid  output  1  c/d/e hold the result of a comparison accepted on the previous edge.

Function
REQ-011 Comparison SHALL be unsigned by default, over all WIDTH bits.
REQ-012 On a rising clk edge with in_valid=1, c/d/e SHALL load (a>b), (a==b), (a<b) respectively, and out_valid SHALL load 1.
REQ-013 Latency SHALL be exactly one clock: operands sampled at edge N appear on c/d/e after edge N.
REQ-014 On a rising edge with in_valid=0, c/d/e SHALL hold their values and out_valid SHALL load 0.
REQ-015 Whenever out_valid=1, exactly one of c, d, e SHALL be 1 (one-hot).
REQ-016 Back-to-back in_valid=1 cycles SHALL be accepted every cycle with no stall; there is no backpressure.
REQ-017 All outputs SHALL be driven directly from flip-flops; no combinational path from a/b/in_valid to any output.
REQ-018 Boundary operands (all-zeros, all-ones, a==b at the maximum value) SHALL compare correctly with no overflow or wrap effects.
REQ-019 Operand changes between clock edges SHALL have no effect on the outputs; only values present at the edge matter.

Reset
REQ-020 While rst=1, c, d, e and out_valid SHALL be 0, asynchronously, independent of clk.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result; the first edge after rst deasserts with in_valid=1 SHALL produce a valid result normally.
REQ-022 Outputs SHALL be all-zero (no flag set) after reset until the first accepted comparison.

Configuration
REQ-023 Macro MAG_CMP_SIGNED_EN SHALL select the comparison mode at compile time.
REQ-024 With MAG_CMP_SIGNED_EN defined, a and b SHALL be compared as two's-complement signed values of WIDTH bits (for WIDTH=2, 2'b10 = -2 < 2'b01 = +1).
REQ-025 Without MAG_CMP_SIGNED_EN, comparison SHALL be unsigned per REQ-011; all other behaviour is identical in both modes.

Verification
REQ-026 Exhaustive sweep: WIDTH=2, all 16 (a,b) pairs with in_valid=1 on successive edges -> each result one cycle later, one-hot, matching unsigned compare (e.g. a=01,b=10 -> c=0,d=0,e=1).
REQ-027 Equality and extremes: a=00,b=00 -> d=1; a=11,b=11 -> d=1; a=11,b=00 -> c=1; a=00,b=11 -> e=1.
REQ-028 Hold: accept a=10,b=01 (c=1), then in_valid=0 with a=00,b=11 for 3 cycles -> c stays 1, d=e=0, out_valid=0.
REQ-029 Async reset: assert rst between clock edges while c=1 -> c=d=e=out_valid=0 immediately; release, accept a=01,b=01 -> d=1, out_valid=1 one cycle later.
REQ-030 Signed mode (MAG_CMP_SIGNED_EN defined, WIDTH=2): a=10,b=01 -> e=1; a=11,b=10 -> c=1; a=01,b=11 -> c=1.
REQ-031 Width scaling: WIDTH=8, a=8'hFF,b=8'hFE -> c=1 unsigned; with MAG_CMP_SIGNED_EN -> c=1 (-1 > -2); a=8'h80,b=8'h7F -> c=1 unsigned, e=1 signed.

Source files
------------

// File: rtl/mag_cmp.sv
// ---------------------------------------------------------------------------
// mag_cmp -- registered magnitude comparator.
//
// Compares two WIDTH-bit operands and registers one-hot greater / equal /
// less flags one clock after the operands are accepted.
//
// Compile-time option:
//   MAG_CMP_SIGNED_EN  defined     -> operands are two's-complement signed
//                      undefined   -> operands are unsigned (default)
//
// Parameters:
//   WIDTH      operand width in bits, 1..32 (default 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears all outputs
//   in_valid   a/b are to be compared on this edge
//   a, b       operands
//   c          registered flag, a >  b
//   d          registered flag, a == b
//   e          registered flag, a <  b
//   out_valid  c/d/e hold a result accepted on the previous edge
// ---------------------------------------------------------------------------
module mag_cmp #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             out_valid
);

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    cmp_res_t res_nxt;
    cmp_res_t res_q;
    logic     vld_q;

    // Equality is mode-independent; only the ordering needs the sign view.
    always_comb begin
        res_nxt    = '0;
        res_nxt.eq = (a == b);
`ifdef MAG_CMP_SIGNED_EN
        res_nxt.gt = ($signed(a) > $signed(b));
        res_nxt.lt = ($signed(a) < $signed(b));
`else
        res_nxt.gt = (a > b);
        res_nxt.lt = (a < b);
`endif
    end

    // Flags only load on an accepted compare, so they keep the last result
    // while idle; the valid bit is what tells a consumer it is fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                res_q <= res_nxt;
            end
        end
    end

    assign c         = res_q.gt;
    assign d         = res_q.eq;
    assign e         = res_q.lt;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_mag_cmp.sv
module tb_mag_cmp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] a = '0;
    logic [1:0] b = '0;
    logic       c, d, e, out_valid;

    logic       in_valid8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8, d8, e8, out_valid8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mag_cmp #(.WIDTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .c(c), .d(d), .e(e), .out_valid(out_valid)
    );

    mag_cmp #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .a(a8), .b(b8),
        .c(c8), .d(d8), .e(e8), .out_valid(out_valid8)
    );

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] cde;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] cde;
    } vec8_t;

    vec_t  vecs[20];
    vec8_t vecs8[4];

    // {out_valid, c, d, e}
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {v,c,d,e}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MAG_CMP_SIGNED_EN
        vecs[0]  = '{2'd0, 2'd0, 3'b010}; vecs[1]  = '{2'd0, 2'd1, 3'b001};
        vecs[2]  = '{2'd0, 2'd2, 3'b100}; vecs[3]  = '{2'd0, 2'd3, 3'b100};
        vecs[4]  = '{2'd1, 2'd0, 3'b100}; vecs[5]  = '{2'd1, 2'd1, 3'b010};
        vecs[6]  = '{2'd1, 2'd2, 3'b100}; vecs[7]  = '{2'd1, 2'd3, 3'b100};
        vecs[8]  = '{2'd2, 2'd0, 3'b001}; vecs[9]  = '{2'd2, 2'd1, 3'b001};
        vecs[10] = '{2'd2, 2'd2, 3'b010}; vecs[11] = '{2'd2, 2'd3, 3'b001};
        vecs[12] = '{2'd3, 2'd0, 3'b001}; vecs[13] = '{2'd3, 2'd1, 3'b001};
        vecs[14] = '{2'd3, 2'd2, 3'b100}; vecs[15] = '{2'd3, 2'd3, 3'b010};
        vecs[16] = '{2'd0, 2'd0, 3'b010}; vecs[17] = '{2'd3, 2'd3, 3'b010};
        vecs[18] = '{2'd3, 2'd0, 3'b001}; vecs[19] = '{2'd0, 2'd3, 3'b100};
        vecs8[0] = '{8'hFF, 8'hFE, 3'b100}; vecs8[1] = '{8'h80, 8'h7F, 3'b001};
        vecs8[2] = '{8'hFF, 8'hFF, 3'b010}; vecs8[3] = '{8'h7F, 8'h80, 3'b100};
`else
        vecs[0]  = '{2'd0, 2'd0, 3'b010}; vecs[1]  = '{2'd0, 2'd1, 3'b001};
        vecs[2]  = '{2'd0, 2'd2, 3'b001}; vecs[3]  = '{2'd0, 2'd3, 3'b001};
        vecs[4]  = '{2'd1, 2'd0, 3'b100}; vecs[5]  = '{2'd1, 2'd1, 3'b010};
        vecs[6]  = '{2'd1, 2'd2, 3'b001}; vecs[7]  = '{2'd1, 2'd3, 3'b001};
        vecs[8]  = '{2'd2, 2'd0, 3'b100}; vecs[9]  = '{2'd2, 2'd1, 3'b100};
        vecs[10] = '{2'd2, 2'd2, 3'b010}; vecs[11] = '{2'd2, 2'd3, 3'b001};
        vecs[12] = '{2'd3, 2'd0, 3'b100}; vecs[13] = '{2'd3, 2'd1, 3'b100};
        vecs[14] = '{2'd3, 2'd2, 3'b100}; vecs[15] = '{2'd3, 2'd3, 3'b010};
        vecs[16] = '{2'd0, 2'd0, 3'b010}; vecs[17] = '{2'd3, 2'd3, 3'b010};
        vecs[18] = '{2'd3, 2'd0, 3'b100}; vecs[19] = '{2'd0, 2'd3, 3'b001};
        vecs8[0] = '{8'hFF, 8'hFE, 3'b100}; vecs8[1] = '{8'h80, 8'h7F, 3'b100};
        vecs8[2] = '{8'hFF, 8'hFF, 3'b010}; vecs8[3] = '{8'h7F, 8'h80, 3'b001};
`endif

        // Reset is asynchronous: outputs clear before any clock edge.
        #2;
        check("reset_async_no_clk", {out_valid, c, d, e}, 4'b0000);
        check("reset_async_no_clk_w8", {out_valid8, c8, d8, e8}, 4'b0000);
        in_valid = 1'b1; a = 2'd3; b = 2'd0;
        tick();
        check("reset_held_over_edge", {out_valid, c, d, e}, 4'b0000);

        // Release between edges, idle edge: still no flag set.
        #2 rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_reset_idle", {out_valid, c, d, e}, 4'b0000);

        // Back-to-back sweep plus extremes, one result per edge.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b;
            tick();
            check($sformatf("vec%0d_a%0d_b%0d", i, vecs[i].a, vecs[i].b),
                  {out_valid, c, d, e}, {1'b1, vecs[i].cde});
            check($sformatf("vec%0d_onehot", i),
                  {3'b000, ($countones({c, d, e}) == 1)}, 4'b0001);
        end

        // Hold: accept a=10,b=01, then idle with changed operands.
        in_valid = 1'b1; a = 2'd2; b = 2'd1;
        tick();
`ifdef MAG_CMP_SIGNED_EN
        check("hold_accept", {out_valid, c, d, e}, 4'b1001);
`else
        check("hold_accept", {out_valid, c, d, e}, 4'b1100);
`endif
        in_valid = 1'b0; a = 2'd0; b = 2'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
`ifdef MAG_CMP_SIGNED_EN
            check($sformatf("hold_idle%0d", k), {out_valid, c, d, e}, 4'b0001);
`else
            check($sformatf("hold_idle%0d", k), {out_valid, c, d, e}, 4'b0100);
`endif
        end

        // Only edge values matter; operand wiggle between edges is ignored.
        in_valid = 1'b1; a = 2'd0; b = 2'd1;
        #2 a = 2'd1; b = 2'd1;
        tick();
        a = 2'd3; b = 2'd0;
        #2;
        check("edge_sample_no_comb_path", {out_valid, c, d, e}, 4'b1010);

        // Async reset mid-cycle while c=1 (a=01,b=00 is greater in both modes).
        in_valid = 1'b1; a = 2'd1; b = 2'd0;
        tick();
        check("pre_reset_gt", {out_valid, c, d, e}, 4'b1100);
        #2 rst = 1'b1;
        #1;
        check("async_reset_mid_cycle", {out_valid, c, d, e}, 4'b0000);
        #1 rst = 1'b0;
        in_valid = 1'b1; a = 2'd1; b = 2'd1;
        tick();
        check("first_after_reset_eq", {out_valid, c, d, e}, 4'b1010);
        in_valid = 1'b0;

        // Width scaling on the 8-bit instance.
        for (int i = 0; i < 4; i++) begin
            in_valid8 = 1'b1; a8 = vecs8[i].a; b8 = vecs8[i].b;
            tick();
            check($sformatf("w8_a%02h_b%02h", vecs8[i].a, vecs8[i].b),
                  {out_valid8, c8, d8, e8}, {1'b1, vecs8[i].cde});
        end
        in_valid8 = 1'b0;
        tick();
        check("w8_idle_drops_valid", {out_valid8, c8, d8, e8}, {1'b0, vecs8[3].cde});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
